// File: rtl/vwrite_stream_pkg.sv
// vwrite_stream_pkg: shared widths, FIFO depth and capture state encoding for vwrite_stream.
package vwrite_stream_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 12;
  localparam int PERIOD_W   = 10;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int LEN_W      = 8;
  localparam int FIFO_DEPTH = 2;
  localparam int BEAT_W     = LEN_W;
  typedef enum logic [1:0] {IDLE, DELAY, WRITE, DONE} cap_state_e;
endpackage

// File: rtl/vwrite_stream_if.sv
// vwrite_stream_if: databus and external dual-port buffer signals of vwrite_stream.
interface vwrite_stream_if;
  import vwrite_stream_pkg::*;
  logic                    databus_ready_0, databus_valid_0, databus_last_0;
  logic [AXI_ADDR_W-1:0]   databus_addr_0;
  logic [AXI_DATA_W-1:0]   databus_rdata_0, databus_wdata_0;
  logic [AXI_DATA_W/8-1:0] databus_wstrb_0;
  logic [LEN_W-1:0]        databus_len_0;
  logic [ADDR_W-1:0]       ext_2p_addr_out_0, ext_2p_addr_in_0;
  logic                    ext_2p_write_0, ext_2p_read_0;
  logic [AXI_DATA_W-1:0]   ext_2p_data_out_0, ext_2p_data_in_0;
  modport master (
    input  databus_ready_0, databus_rdata_0, databus_last_0, ext_2p_data_in_0,
    output databus_valid_0, databus_addr_0, databus_wdata_0, databus_wstrb_0, databus_len_0,
           ext_2p_addr_out_0, ext_2p_addr_in_0, ext_2p_write_0, ext_2p_read_0, ext_2p_data_out_0
  );
  modport slave (
    output databus_ready_0, databus_rdata_0, databus_last_0, ext_2p_data_in_0,
    input  databus_valid_0, databus_addr_0, databus_wdata_0, databus_wstrb_0, databus_len_0,
           ext_2p_addr_out_0, ext_2p_addr_in_0, ext_2p_write_0, ext_2p_read_0, ext_2p_data_out_0
  );
endinterface

// File: rtl/vwrite_stream_memory_reader.sv
// memory_reader: issues buffer reads 0..length-1, absorbs the read latency in a 2-entry FIFO, presents beats.
module memory_reader
  import vwrite_stream_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  done_b_i,
  input  logic                  msb_i,
  input  logic                  ready_i,
  input  logic [LEN_W-1:0]      length_i,
  input  logic [AXI_DATA_W-1:0] rdata_i,
  output logic                  rd_o,
  output logic [ADDR_W-1:0]     raddr_o,
  output logic                  valid_o,
  output logic [AXI_DATA_W-1:0] wdata_o
);
  logic [BEAT_W-1:0]     rcnt_q;
  logic                  inflight_q, wp_q, rp_q, pop;
  logic [1:0]            cnt_q, occ;
  logic [AXI_DATA_W-1:0] mem_q [FIFO_DEPTH];
  assign valid_o = cnt_q != 2'd0 && !done_b_i;
  assign pop     = valid_o && ready_i;
  // occupancy counted after this cycle's pop so a held-high ready sustains one beat per cycle
  assign occ     = cnt_q - 2'(pop) + 2'(inflight_q);
  assign rd_o    = !done_b_i && rcnt_q < length_i && occ < 2'(FIFO_DEPTH);
  assign raddr_o = rd_o ? {msb_i, (ADDR_W-1)'(rcnt_q)} : '0;
  assign wdata_o = mem_q[rp_q];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rcnt_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
    end else if (start_i) begin
      rcnt_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
    end else begin
      rcnt_q     <= rcnt_q + BEAT_W'(rd_o);
      inflight_q <= rd_o;
      cnt_q      <= cnt_q + 2'(inflight_q) - 2'(pop);
      wp_q       <= wp_q ^ inflight_q;
      rp_q       <= rp_q ^ pop;
    end
  always_ff @(posedge clk)
    if (inflight_q) mem_q[wp_q] <= rdata_i;
endmodule

// File: rtl/vwrite_stream.sv
// vwrite_stream: captures in0 into the dual-port buffer and drains it to memory as a burst.
// Define VWRITE_STREAM_PINGPONG_EN to alternate buffer halves between runs.
module vwrite_stream
  import vwrite_stream_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  running,
  input  logic                  run,
  output logic                  done,
  input  logic [DATA_W-1:0]     in0,
  vwrite_stream_if.master       bus,
  input  logic [AXI_ADDR_W-1:0] ext_addr,
  input  logic [LEN_W-1:0]      length,
  input  logic                  pingPong,
  input  logic [ADDR_W-1:0]     startA,
  input  logic [ADDR_W-1:0]     incrA,
  input  logic [ADDR_W-1:0]     shiftA,
  input  logic [PERIOD_W-1:0]   perA,
  input  logic [PERIOD_W-1:0]   iterA,
  input  logic                  disabled,
  input  logic [31:0]           delay0
);
  cap_state_e            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d, raddr;
  logic [PERIOD_W-1:0]   pcnt_q, pcnt_d, icnt_q, icnt_d;
  logic [31:0]           dcnt_q, dcnt_d;
  logic [AXI_ADDR_W-1:0] bus_addr_q;
  logic [AXI_DATA_W-1:0] wdata;
  logic                  done_b_q, start, wrap, acc, rd, valid, drain_msb, unused;
  assign start  = run && !disabled;
  assign wrap   = pcnt_q == perA - PERIOD_W'(1);
  assign acc    = valid && bus.databus_ready_0;
  assign done   = (state_q == IDLE || state_q == DONE) && done_b_q;
  assign unused = ^{running, pingPong, bus.databus_rdata_0};
`ifdef VWRITE_STREAM_PINGPONG_EN
  logic pp_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) pp_q <= 1'b0;
    else if (start) pp_q <= pingPong && !pp_q;
  assign drain_msb             = !pp_q;
  assign bus.ext_2p_addr_out_0 = {pp_q, addr_q[ADDR_W-2:0]};
`else
  assign drain_msb             = 1'b0;
  assign bus.ext_2p_addr_out_0 = addr_q;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pcnt_d  = pcnt_q;
    icnt_d  = icnt_q;
    dcnt_d  = dcnt_q;
    if (start) begin
      addr_d  = startA;
      pcnt_d  = '0;
      icnt_d  = '0;
      dcnt_d  = delay0 - 32'd1;
      state_d = (perA == '0 || iterA == '0) ? DONE : (delay0 == 32'd0) ? WRITE : DELAY;
    end else if (state_q == DELAY) begin
      dcnt_d  = dcnt_q - 32'd1;
      state_d = dcnt_q == 32'd0 ? WRITE : DELAY;
    end else if (state_q == WRITE) begin
      pcnt_d  = wrap ? '0 : pcnt_q + PERIOD_W'(1);
      icnt_d  = wrap ? icnt_q + PERIOD_W'(1) : icnt_q;
      addr_d  = addr_q + incrA + (wrap ? shiftA : '0);
      state_d = (wrap && icnt_q == iterA - PERIOD_W'(1)) ? DONE : WRITE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pcnt_q  <= '0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pcnt_q  <= pcnt_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
    end
  // a start on the same edge as the last beat wins
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      done_b_q   <= 1'b1;
      bus_addr_q <= '0;
    end else if (start) begin
      done_b_q   <= length == '0;
      bus_addr_q <= ext_addr;
    end else if (acc && bus.databus_last_0) done_b_q <= 1'b1;
  memory_reader u_reader (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .done_b_i (done_b_q),
    .msb_i    (drain_msb),
    .ready_i  (bus.databus_ready_0),
    .length_i (length),
    .rdata_i  (bus.ext_2p_data_in_0),
    .rd_o     (rd),
    .raddr_o  (raddr),
    .valid_o  (valid),
    .wdata_o  (wdata)
  );
  assign bus.databus_valid_0   = valid;
  assign bus.databus_addr_0    = bus_addr_q;
  assign bus.databus_wdata_0   = wdata;
  assign bus.databus_wstrb_0   = {(AXI_DATA_W/8){valid}};
  assign bus.databus_len_0     = length;
  assign bus.ext_2p_write_0    = state_q == WRITE;
  assign bus.ext_2p_data_out_0 = in0;
  assign bus.ext_2p_read_0     = rd;
  assign bus.ext_2p_addr_in_0  = raddr;
endmodule

// File: tb/tb_vwrite_stream.sv
// tb_vwrite_stream: directed checks of capture, drain, stalls, disable, reset and ping-pong.
module tb_vwrite_stream;
  import vwrite_stream_pkg::*;
  logic clk = 1'b0, rst = 1'b1, running = 1'b0, run = 1'b0, pingPong = 1'b0, disabled = 1'b0, done;
  logic [DATA_W-1:0]     in0 = '0;
  logic [AXI_ADDR_W-1:0] ext_addr = 32'h1000_0000;
  logic [LEN_W-1:0]      length = 8'd4;
  logic [ADDR_W-1:0]     startA = '0, incrA = 12'd1, shiftA = '0;
  logic [PERIOD_W-1:0]   perA = 10'd4, iterA = 10'd2;
  logic [31:0]           delay0 = 32'd3;
  logic                  ready = 1'b1, pre_we = 1'b0, stall;
  logic [ADDR_W-1:0]     pre_a = '0;
  logic [31:0]           pre_d = '0, rd_q = '0, held;
  logic [LEN_W-1:0]      nbeats = '0;
  logic [31:0]           bmem [4096];
  int vectors = 0, errs = 0, got;
  vwrite_stream_if bif ();
  vwrite_stream dut (
    .clk(clk), .rst(rst), .running(running), .run(run), .done(done), .in0(in0), .bus(bif),
    .ext_addr(ext_addr), .length(length), .pingPong(pingPong), .startA(startA), .incrA(incrA),
    .shiftA(shiftA), .perA(perA), .iterA(iterA), .disabled(disabled), .delay0(delay0)
  );
  always #5 clk = ~clk;
  assign bif.databus_ready_0   = ready;
  assign bif.databus_rdata_0   = '0;
  assign bif.databus_last_0    = bif.databus_valid_0 && nbeats == length - 8'd1;
  assign bif.ext_2p_data_in_0  = rd_q;
  always @(posedge clk) begin
    if (pre_we) bmem[pre_a] <= pre_d;
    else if (bif.ext_2p_write_0) bmem[bif.ext_2p_addr_out_0] <= bif.ext_2p_data_out_0;
    if (bif.ext_2p_read_0) rd_q <= bmem[bif.ext_2p_addr_in_0];
    if (run) nbeats <= '0;
    else if (bif.databus_valid_0 && ready) nbeats <= nbeats + 8'd1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_run();
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 64'(done), 64'(1'b1));
    chk("rst_valid", 64'(bif.databus_valid_0), 64'(1'b0));
    chk("rst_write", 64'(bif.ext_2p_write_0), 64'(1'b0));
    chk("rst_read", 64'(bif.ext_2p_read_0), 64'(1'b0));
    chk("rst_baddr", 64'(bif.databus_addr_0), 64'(0));
    for (int i = 0; i < 4; i++) begin
      pre_we = 1'b1; pre_a = ADDR_W'(i); pre_d = 32'hA0 + i;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    // run 1: capture 8 words after delay 3 while draining the preloaded A0..A3
    pulse_run();
    for (int c = 1; c <= 13; c++) begin
      in0 = 32'hC0 + c;
      @(negedge clk);
      chk("cap_write", 64'(bif.ext_2p_write_0), 64'(c >= 4 && c <= 11));
      if (c >= 4 && c <= 11) begin
        chk("cap_addr", 64'(bif.ext_2p_addr_out_0), 64'(c - 4));
        chk("cap_data", 64'(bif.ext_2p_data_out_0), 64'(32'hC0 + c));
      end
      chk("drn_read", 64'(bif.ext_2p_read_0), 64'(c <= 4));
      if (c <= 4) chk("drn_raddr", 64'(bif.ext_2p_addr_in_0), 64'(c - 1));
      chk("drn_valid", 64'(bif.databus_valid_0), 64'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("drn_beat", 64'(bif.databus_wdata_0), 64'(32'hA0 + c - 3));
      chk("drn_strb", 64'(bif.databus_wstrb_0), (c >= 3 && c <= 6) ? 64'hF : 64'h0);
      chk("done", 64'(done), 64'(c >= 12));
      if (c == 1) begin
        chk("bus_addr", 64'(bif.databus_addr_0), 64'h1000_0000);
        chk("bus_len", 64'(bif.databus_len_0), 64'd4);
      end
      @(posedge clk); #1;
    end
    // run 2: drain the captured C4..C7 with ready pattern 1,0,0,...
    perA = '0;
    pulse_run();
    got = 0; stall = 1'b0; held = '0;
    for (int k = 0; k < 30; k++) begin
      ready = (k % 3 == 0);
      @(negedge clk);
      if (k == 0) chk("t2_done_low", 64'(done), 64'(1'b0));
      if (stall) chk("t2_stable", 64'(bif.databus_wdata_0), 64'(held));
      if (bif.databus_valid_0 && ready) begin
        chk("t2_beat", 64'(bif.databus_wdata_0), 64'(32'hC4 + got));
        got++;
      end
      stall = bif.databus_valid_0 && !ready;
      held  = bif.databus_wdata_0;
      @(posedge clk); #1;
    end
    ready = 1'b1;
    chk("t2_count", 64'(got), 64'd4);
    chk("t2_done", 64'(done), 64'(1'b1));
    // disabled start is ignored
    disabled = 1'b1; ext_addr = 32'h2000_0000;
    pulse_run();
    @(negedge clk);
    chk("dis_done", 64'(done), 64'(1'b1));
    chk("dis_read", 64'(bif.ext_2p_read_0), 64'(1'b0));
    chk("dis_baddr", 64'(bif.databus_addr_0), 64'h1000_0000);
    @(posedge clk); #1;
    disabled = 1'b0;
    // length 0 and iterA 0: both sides finish the cycle after start
    length = '0; perA = 10'd4; iterA = '0;
    pulse_run();
    @(negedge clk);
    chk("zero_done", 64'(done), 64'(1'b1));
    chk("zero_read", 64'(bif.ext_2p_read_0), 64'(1'b0));
    chk("zero_write", 64'(bif.ext_2p_write_0), 64'(1'b0));
    chk("zero_baddr", 64'(bif.databus_addr_0), 64'h2000_0000);
    @(posedge clk); #1;
    // reset in the middle of capture and a stalled drain
    length = 8'd4; iterA = 10'd2; delay0 = '0; ready = 1'b0;
    pulse_run();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_valid", 64'(bif.databus_valid_0), 64'(1'b1));
    chk("mid_write", 64'(bif.ext_2p_write_0), 64'(1'b1));
    chk("mid_done", 64'(done), 64'(1'b0));
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bif.databus_valid_0), 64'(1'b0));
    chk("arst_write", 64'(bif.ext_2p_write_0), 64'(1'b0));
    chk("arst_read", 64'(bif.ext_2p_read_0), 64'(1'b0));
    chk("arst_done", 64'(done), 64'(1'b1));
    chk("arst_baddr", 64'(bif.databus_addr_0), 64'(0));
    chk("arst_strb", 64'(bif.databus_wstrb_0), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
`ifdef VWRITE_STREAM_PINGPONG_EN
    pingPong = 1'b1; length = 8'd2; perA = 10'd2; iterA = 10'd1; in0 = 32'hBEEF_0001;
    pulse_run();
    @(negedge clk);
    chk("pp1_waddr", 64'(bif.ext_2p_addr_out_0), 64'h800);
    chk("pp1_raddr", 64'(bif.ext_2p_addr_in_0), 64'h000);
    repeat (6) @(posedge clk);
    #1;
    in0 = 32'h0;
    pulse_run();
    @(negedge clk);
    chk("pp2_waddr", 64'(bif.ext_2p_addr_out_0), 64'h000);
    chk("pp2_raddr", 64'(bif.ext_2p_addr_in_0), 64'h800);
    @(posedge clk); #1;
    got = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bif.databus_valid_0 && ready) begin
        chk("pp2_beat", 64'(bif.databus_wdata_0), 64'hBEEF_0001);
        got++;
      end
      @(posedge clk); #1;
    end
    chk("pp2_count", 64'(got), 64'd2);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
